// File: rtl/raycast_pkg.sv
// Shared ray-cast definitions: dispatcher state encoding, frame geometry defaults, pointer sizing.
// Imported by the dispatcher, its arbiter, and the render FSM / lane blocks.
package raycast_pkg;

  localparam int NUM_COLS_DEF = 640;
  localparam int IDX_W_DEF    = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2
  } disp_state_e;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_dispatcher_if.sv
// Handshake bundle between the column dispatcher, the render FSM and the ray-cast lanes.
// master = dispatcher side, slave = render FSM / lanes side.
interface ray_dispatcher_if #(
  parameter int NUM_LANES = 2,
  parameter int IDX_W     = raycast_pkg::IDX_W_DEF
);

  logic                 frame_start;
  logic                 abort;
  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] lane_done;
  logic [NUM_LANES-1:0] lane_valid;
  logic [IDX_W-1:0]     lane_index;
  logic                 busy;
  logic                 frame_done;
  logic                 frame_aborted;
  logic                 switch_state;
  logic                 proto_err;

  modport master (
    input  frame_start, abort, lane_ready, lane_done,
    output lane_valid, lane_index, busy, frame_done, frame_aborted, switch_state, proto_err
  );

  modport slave (
    output frame_start, abort, lane_ready, lane_done,
    input  lane_valid, lane_index, busy, frame_done, frame_aborted, switch_state, proto_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: ptr_i is the highest-priority lane, search wraps upward from it.
// Latency: combinational; no backpressure (grant is zero when nothing requests).
module rr_arbiter import raycast_pkg::*; #(
  parameter int N     = 2,
  parameter int PTR_W = ptr_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j[PTR_W-1:0]] && (j >= int'(ptr_i))) begin
        gnt_o[j[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
    // wrap-around pass: lanes below the pointer
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j[PTR_W-1:0]] && (j < int'(ptr_i))) begin
        gnt_o[j[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Frame column dispatcher: issues indices 0..NUM_COLS-1 round-robin to ready lanes, then drains.
// Latency: grant decided in cycle t, strobe at t+1; a lane is held off while busy or not ready.
module ray_dispatcher import raycast_pkg::*; #(
  parameter int NUM_COLS  = NUM_COLS_DEF,
  parameter int IDX_W     = IDX_W_DEF,
  parameter int NUM_LANES = 2
) (
  input logic              clk,
  input logic              reset,
  ray_dispatcher_if.master bus
);

  localparam int CNT_W = IDX_W + 1;
  localparam int PTR_W = ptr_w(NUM_LANES);
  localparam logic [CNT_W-1:0] COLS = CNT_W'(NUM_COLS);

  disp_state_e          state_q, state_d;
  logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;
  logic [NUM_LANES-1:0] lane_busy_q, lane_busy_d;
  logic [NUM_LANES-1:0] lane_valid_q, lane_valid_d;
  logic [IDX_W-1:0]     lane_index_q, lane_index_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_aborted_q, frame_aborted_d;
  logic                 switch_q, switch_d;
  logic                 proto_err_q, proto_err_d;

  logic [NUM_LANES-1:0] req, gnt, done_ok;
  logic                 issuing;

  // a lane finishing this cycle still counts as busy, so it cannot be re-granted until next cycle
  assign issuing = (state_q == ST_DISPATCH) && (issue_cnt_q < COLS);
  assign req     = bus.lane_ready & ~lane_busy_q & {NUM_LANES{issuing}};
  assign done_ok = bus.lane_done & lane_busy_q;

  rr_arbiter #(.N(NUM_LANES), .PTR_W(PTR_W)) u_arb (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d         = state_q;
    issue_cnt_d     = issue_cnt_q;
    done_cnt_d      = done_cnt_q + CNT_W'($countones(done_ok));
    lane_busy_d     = (lane_busy_q & ~done_ok) | gnt;
    lane_valid_d    = gnt;
    lane_index_d    = lane_index_q;
    rr_ptr_d        = rr_ptr_q;
    frame_done_d    = 1'b0;
    frame_aborted_d = 1'b0;
    switch_d        = (|gnt) | (|done_ok);
    proto_err_d     = proto_err_q | (|(bus.lane_done & ~lane_busy_q));

    if (|gnt) begin
      issue_cnt_d  = issue_cnt_q + CNT_W'(1);
      lane_index_d = issue_cnt_q[IDX_W-1:0];
    end
    for (int k = 0; k < NUM_LANES; k++) begin
      if (gnt[k[PTR_W-1:0]]) rr_ptr_d = (k == NUM_LANES - 1) ? '0 : PTR_W'(k + 1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_d     = ST_DISPATCH;
          issue_cnt_d = '0;
          done_cnt_d  = '0;
        end
      end
      ST_DISPATCH: begin
        if (bus.abort || (issue_cnt_q == COLS)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (lane_busy_q == '0) begin
          state_d         = ST_IDLE;
          frame_done_d    = (done_cnt_q == COLS);
          frame_aborted_d = (done_cnt_q != COLS);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      issue_cnt_q     <= '0;
      done_cnt_q      <= '0;
      lane_busy_q     <= '0;
      lane_valid_q    <= '0;
      lane_index_q    <= '0;
      rr_ptr_q        <= '0;
      frame_done_q    <= 1'b0;
      frame_aborted_q <= 1'b0;
      switch_q        <= 1'b1;
      proto_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_cnt_q     <= issue_cnt_d;
      done_cnt_q      <= done_cnt_d;
      lane_busy_q     <= lane_busy_d;
      lane_valid_q    <= lane_valid_d;
      lane_index_q    <= lane_index_d;
      rr_ptr_q        <= rr_ptr_d;
      frame_done_q    <= frame_done_d;
      frame_aborted_q <= frame_aborted_d;
      switch_q        <= switch_d;
      proto_err_q     <= proto_err_d;
    end
  end

  assign bus.lane_valid    = lane_valid_q;
  assign bus.lane_index    = lane_index_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_aborted = frame_aborted_q;
  assign bus.switch_state  = switch_q;
  assign bus.proto_err     = proto_err_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher: frame-level reference model compared every cycle, plus literal pins.
// Lanes are emulated with per-lane completion delays driven from the model's expected issues.
module tb_ray_dispatcher;

  localparam int NC = 8;
  localparam int IW = 4;
  localparam int NL = 2;

  logic clk;
  logic reset;

  ray_dispatcher_if #(.NUM_LANES(NL), .IDX_W(IW)) bus ();

  ray_dispatcher #(.NUM_COLS(NC), .IDX_W(IW), .NUM_LANES(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model: frame phase, counts of issued/completed rays, outstanding lanes
  int      m_state, m_issued, m_done, m_prio;
  bit      m_busy [NL];
  logic [NL-1:0] e_valid;
  logic [IW-1:0] e_index;
  logic    e_busy, e_fdone, e_fab, e_sw, e_perr;

  // emulated lanes
  int      t     [NL];
  int      delay [NL];
  logic [NL-1:0] extra_dn;

  // DUT observations for literal checks
  int first_valid_cyc, fdone_cnt, fab_cnt, lane1_strobes, busy_viol;
  int idx_q[$];
  int lane_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_obs();
    first_valid_cyc = -1;
    fdone_cnt = 0;
    fab_cnt = 0;
    lane1_strobes = 0;
    busy_viol = 0;
    idx_q.delete();
    lane_q.delete();
  endtask

  task automatic model_step(input logic rst, input logic fs, input logic ab,
                            input logic [NL-1:0] rdy, input logic [NL-1:0] dn);
    int g, k, ncomp, nstate;
    bit any_busy;
    if (rst) begin
      m_state = 0; m_issued = 0; m_done = 0; m_prio = 0;
      for (int i = 0; i < NL; i++) m_busy[i] = 1'b0;
      e_valid = '0; e_index = '0; e_busy = 1'b0; e_fdone = 1'b0;
      e_fab = 1'b0; e_sw = 1'b1; e_perr = 1'b0;
      return;
    end
    g = -1;
    if (m_state == 1 && m_issued < NC) begin
      for (int i = 0; i < NL; i++) begin
        k = (m_prio + i) % NL;
        if (g < 0 && rdy[k] && !m_busy[k]) g = k;
      end
    end
    ncomp = 0;
    any_busy = 1'b0;
    for (int i = 0; i < NL; i++) begin
      any_busy |= m_busy[i];
      if (dn[i]) begin
        if (m_busy[i]) ncomp++;
        else e_perr = 1'b1;
      end
    end
    e_sw = (g >= 0) || (ncomp > 0);
    e_valid = '0;
    e_fdone = 1'b0;
    e_fab = 1'b0;
    if (g >= 0) begin
      e_valid[g] = 1'b1;
      e_index = IW'(m_issued);
    end
    nstate = m_state;
    case (m_state)
      0: if (fs) nstate = 1;
      1: if (ab || m_issued == NC) nstate = 2;
      default: if (!any_busy) begin
        nstate = 0;
        if (m_done == NC) e_fdone = 1'b1;
        else e_fab = 1'b1;
      end
    endcase
    for (int i = 0; i < NL; i++) if (dn[i]) m_busy[i] = 1'b0;
    if (g >= 0) begin
      m_busy[g] = 1'b1;
      m_issued++;
      m_prio = (g + 1) % NL;
    end
    m_done += ncomp;
    if (m_state == 0 && nstate == 1) begin
      m_issued = 0;
      m_done = 0;
    end
    m_state = nstate;
    e_busy = (nstate != 0);
  endtask

  task automatic tick(input logic fs, input logic ab, input logic [NL-1:0] rdy);
    logic [NL-1:0] dn;
    dn = extra_dn;
    for (int i = 0; i < NL; i++) begin
      if (t[i] == 1) dn[i] = 1'b1;
      if (t[i] > 0) t[i]--;
    end
    bus.frame_start = fs;
    bus.abort       = ab;
    bus.lane_ready  = rdy;
    bus.lane_done   = dn;
    @(posedge clk);
    model_step(reset, fs, ab, rdy, dn);
    #1;
    cyc++;
    chk("lane_valid",    32'(bus.lane_valid),    32'(e_valid));
    chk("lane_index",    32'(bus.lane_index),    32'(e_index));
    chk("busy",          32'(bus.busy),          32'(e_busy));
    chk("frame_done",    32'(bus.frame_done),    32'(e_fdone));
    chk("frame_aborted", 32'(bus.frame_aborted), 32'(e_fab));
    chk("switch_state",  32'(bus.switch_state),  32'(e_sw));
    chk("proto_err",     32'(bus.proto_err),     32'(e_perr));
    if (bus.lane_valid != '0) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      idx_q.push_back(int'(bus.lane_index));
      lane_q.push_back(bus.lane_valid[1] ? 1 : 0);
      if (bus.lane_valid[1]) lane1_strobes++;
      if (bus.lane_valid[0] && t[0] > 0) busy_viol++;
    end
    if (bus.frame_done) fdone_cnt++;
    if (bus.frame_aborted) fab_cnt++;
    for (int i = 0; i < NL; i++) if (e_valid[i]) t[i] = delay[i] + 1;
  endtask

  task automatic run_to_idle(input string name, input logic [NL-1:0] rdy, input int fs_at);
    int n;
    n = 0;
    while (e_busy && n < 100) begin
      tick(n == fs_at, 1'b0, rdy);
      n++;
    end
    chk(name, 32'(n < 100), 32'd1);
  endtask

  initial begin
    int n;
    bus.frame_start = 1'b0;
    bus.abort = 1'b0;
    bus.lane_ready = '0;
    bus.lane_done = '0;
    extra_dn = '0;
    for (int i = 0; i < NL; i++) begin
      t[i] = 0;
      delay[i] = 3;
    end
    clear_obs();

    // reset and idle until cycle 10
    reset = 1'b1;
    tick(1'b0, 1'b0, 2'b11);
    tick(1'b0, 1'b0, 2'b11);
    chk("reset_switch_state", 32'(bus.switch_state), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    while (cyc < 10) tick(1'b0, 1'b0, 2'b11);

    // full frame, both lanes ready, done 3 cycles after issue; stray frame_start mid-frame
    tick(1'b1, 1'b0, 2'b11);
    run_to_idle("t1_drain_bound", 2'b11, 4);
    chk("t1_done_busy_low", 32'({bus.frame_done, bus.busy}), 32'd2);
    chk("t1_first_valid_cycle", 32'(first_valid_cyc), 32'd12);
    chk("t1_issue_count", 32'(idx_q.size()), 32'd8);
    for (int i = 0; i < idx_q.size() && i < 8; i++) begin
      chk("t1_index_order", 32'(idx_q[i]), 32'(i));
      chk("t1_lane_alternate", 32'(lane_q[i]), 32'(i % 2));
    end
    chk("t1_frame_done_once", 32'(fdone_cnt), 32'd1);
    chk("t1_no_abort", 32'(fab_cnt), 32'd0);
    tick(1'b0, 1'b0, 2'b11);

    // abort right after index 3 is strobed
    clear_obs();
    tick(1'b1, 1'b0, 2'b11);
    n = 0;
    while (!(e_valid != '0 && e_index == 4'd3) && n < 50) begin
      tick(1'b0, 1'b0, 2'b11);
      n++;
    end
    chk("t2_reach_idx3_bound", 32'(n < 50), 32'd1);
    tick(1'b0, 1'b1, 2'b11);
    run_to_idle("t2_drain_bound", 2'b11, -1);
    chk("t2_last_index", 32'(idx_q.size() > 0 ? idx_q[idx_q.size()-1] : -1), 32'd3);
    chk("t2_issue_count", 32'(idx_q.size()), 32'd4);
    chk("t2_aborted_once", 32'(fab_cnt), 32'd1);
    chk("t2_no_frame_done", 32'(fdone_cnt), 32'd0);

    // restart with lane1 never ready
    clear_obs();
    tick(1'b1, 1'b0, 2'b01);
    run_to_idle("t3_drain_bound", 2'b01, -1);
    chk("t3_first_index", 32'(idx_q.size() > 0 ? idx_q[0] : -1), 32'd0);
    chk("t3_issue_count", 32'(idx_q.size()), 32'd8);
    chk("t3_lane1_strobes", 32'(lane1_strobes), 32'd0);
    chk("t3_lane0_busy_strobe", 32'(busy_viol), 32'd0);
    chk("t3_frame_done_once", 32'(fdone_cnt), 32'd1);

    // simultaneous completions on both lanes, then lane_done on an idle lane
    clear_obs();
    delay[0] = 4;
    delay[1] = 3;
    tick(1'b1, 1'b0, 2'b11);
    run_to_idle("t4_drain_bound", 2'b11, -1);
    chk("t4_frame_done_once", 32'(fdone_cnt), 32'd1);
    chk("t4_no_abort", 32'(fab_cnt), 32'd0);
    chk("t4_proto_err_clear", 32'(bus.proto_err), 32'd0);
    extra_dn = 2'b10;
    tick(1'b0, 1'b0, 2'b11);
    extra_dn = '0;
    chk("t4_proto_err_set", 32'(bus.proto_err), 32'd1);
    tick(1'b0, 1'b0, 2'b11);
    chk("t4_proto_err_sticky", 32'(bus.proto_err), 32'd1);

    // reset with two rays in flight, then late completions
    delay[0] = 3;
    delay[1] = 3;
    reset = 1'b1;
    tick(1'b0, 1'b0, 2'b11);
    reset = 1'b0;
    chk("t5_proto_err_reset", 32'(bus.proto_err), 32'd0);
    tick(1'b1, 1'b0, 2'b11);
    n = 0;
    while (!(m_busy[0] && m_busy[1]) && n < 20) begin
      tick(1'b0, 1'b0, 2'b11);
      n++;
    end
    chk("t5_inflight_bound", 32'(n < 20), 32'd1);
    reset = 1'b1;
    tick(1'b0, 1'b0, 2'b11);
    reset = 1'b0;
    chk("t5_reset_valid", 32'(bus.lane_valid), 32'd0);
    chk("t5_reset_busy", 32'(bus.busy), 32'd0);
    chk("t5_reset_switch", 32'(bus.switch_state), 32'd1);
    chk("t5_reset_index", 32'(bus.lane_index), 32'd0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 2'b11);
    chk("t5_late_done_err", 32'(bus.proto_err), 32'd1);
    chk("t5_stays_idle", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
